// File: rtl/me_protocol_monitor.sv
// Start/completed handshake monitor for the motion-estimation engine: tracks each
// search, measures latency, enforces a timeout and reports protocol errors.
module me_protocol_monitor #(
  parameter int DIST_W  = 8,
  parameter int MV_W    = 4,
  parameter int MV_MIN  = -8,
  parameter int MV_MAX  = 7,
  parameter int TIMEOUT = 4096,
  parameter int LAT_W   = 16,
  parameter int CNT_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              completed,
  input  logic [DIST_W-1:0] BestDist,
  input  logic [MV_W-1:0]   motionX,
  input  logic [MV_W-1:0]   motionY,
  input  logic              clear_errors,
  output logic              busy,
  output logic [4:0]        err_flags,
  output logic [CNT_W-1:0]  err_count,
  output logic              irq,
  output logic [CNT_W-1:0]  search_count,
  output logic [LAT_W-1:0]  last_latency,
  output logic [LAT_W-1:0]  max_latency
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  localparam logic signed [MV_W-1:0] LP_MV_MIN  = MV_MIN[MV_W-1:0];
  localparam logic signed [MV_W-1:0] LP_MV_MAX  = MV_MAX[MV_W-1:0];
  localparam logic [LAT_W-1:0]       LP_TIMEOUT = TIMEOUT[LAT_W-1:0];

  state_t              r_state, w_state_nxt;
  logic [LAT_W-1:0]    r_lat, w_lat_nxt;
  logic                r_prev_cmp;
  logic [DIST_W-1:0]   r_cap_dist;
  logic [MV_W-1:0]     r_cap_mx;
  logic [MV_W-1:0]     r_cap_my;
  logic [4:0]          r_flags;
  logic [CNT_W-1:0]    r_err_cnt;
  logic                r_irq;
  logic [CNT_W-1:0]    r_search_cnt;
  logic [LAT_W-1:0]    r_last_lat;
  logic [LAT_W-1:0]    r_max_lat;

  logic                w_accept;
  logic                w_mv_bad;
  logic                w_unstable;
  logic [4:0]          w_err;
  logic                w_any_err;

  always_comb begin
    w_accept   = (r_state == ST_BUSY) && completed && !start;
    w_mv_bad   = ($signed(motionX) < LP_MV_MIN) || ($signed(motionX) > LP_MV_MAX) ||
                 ($signed(motionY) < LP_MV_MIN) || ($signed(motionY) > LP_MV_MAX);
    w_unstable = (BestDist != r_cap_dist) || (motionX != r_cap_mx) || (motionY != r_cap_my);

    w_err      = '0;
    w_err[0]   = start && completed;
    w_err[1]   = (r_state == ST_BUSY) && (r_lat == LP_TIMEOUT) && !completed;
    w_err[2]   = w_accept && w_mv_bad;
    w_err[3]   = (r_state == ST_DONE) && completed && w_unstable;
    w_err[4]   = (r_state == ST_IDLE) && completed && !r_prev_cmp;
    w_any_err  = |w_err;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lat_nxt   = r_lat;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_BUSY;
          w_lat_nxt   = LAT_W'(1);
        end
      end
      ST_BUSY: begin
        // Acceptance is checked first so a completion in cycle TIMEOUT is not a timeout.
        if (w_accept) begin
          w_state_nxt = ST_DONE;
        end else if (w_err[1]) begin
          w_state_nxt = ST_IDLE;
        end else if (r_lat != '1) begin
          w_lat_nxt = r_lat + LAT_W'(1);
        end
      end
      ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_BUSY;
          w_lat_nxt   = LAT_W'(1);
        end else if (!completed) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_lat        <= '0;
      r_prev_cmp   <= 1'b0;
      r_cap_dist   <= '0;
      r_cap_mx     <= '0;
      r_cap_my     <= '0;
      r_flags      <= '0;
      r_err_cnt    <= '0;
      r_irq        <= 1'b0;
      r_search_cnt <= '0;
      r_last_lat   <= '0;
      r_max_lat    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lat      <= w_lat_nxt;
      r_prev_cmp <= completed;
      r_irq      <= w_any_err;

      // A detection in the clearing cycle survives the clear.
      if (clear_errors) begin
        r_flags   <= w_err;
        r_err_cnt <= CNT_W'(w_any_err);
      end else begin
        r_flags <= r_flags | w_err;
        if (w_any_err && (r_err_cnt != '1)) begin
          r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
      end

      if (w_accept) begin
        r_cap_dist <= BestDist;
        r_cap_mx   <= motionX;
        r_cap_my   <= motionY;
        r_last_lat <= r_lat;
        if (r_lat > r_max_lat) begin
          r_max_lat <= r_lat;
        end
        if (r_search_cnt != '1) begin
          r_search_cnt <= r_search_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign busy         = (r_state == ST_BUSY);
  assign err_flags    = r_flags;
  assign err_count    = r_err_cnt;
  assign irq          = r_irq;
  assign search_count = r_search_cnt;
  assign last_latency = r_last_lat;
  assign max_latency  = r_max_lat;

endmodule

// File: tb/tb_me_protocol_monitor.sv
// Scoreboard bench for me_protocol_monitor: a timestamp-based reference model queues
// the expected outputs per clock; a monitor process pops and compares them.
module tb_me_protocol_monitor;

  localparam int DIST_W  = 8;
  localparam int MV_W    = 4;
  localparam int MV_MIN  = -7;
  localparam int MV_MAX  = 6;
  localparam int TIMEOUT = 16;
  localparam int LAT_W   = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;
  localparam int LAT_MAX = 255;

  logic              clk = 1'b0;
  logic              rst;
  logic              start, completed, clear_errors;
  logic [DIST_W-1:0] BestDist;
  logic [MV_W-1:0]   motionX, motionY;
  logic              busy, irq;
  logic [4:0]        err_flags;
  logic [CNT_W-1:0]  err_count, search_count;
  logic [LAT_W-1:0]  last_latency, max_latency;

  always #5 clk = ~clk;

  me_protocol_monitor #(
    .DIST_W(DIST_W), .MV_W(MV_W), .MV_MIN(MV_MIN), .MV_MAX(MV_MAX),
    .TIMEOUT(TIMEOUT), .LAT_W(LAT_W), .CNT_W(CNT_W)
  ) dut (
    .clock(clk), .reset(rst), .start(start), .completed(completed),
    .BestDist(BestDist), .motionX(motionX), .motionY(motionY),
    .clear_errors(clear_errors), .busy(busy), .err_flags(err_flags),
    .err_count(err_count), .irq(irq), .search_count(search_count),
    .last_latency(last_latency), .max_latency(max_latency)
  );

  typedef struct {
    logic       busy;
    logic       irq;
    logic [4:0] flags;
    int         cnt;
    int         sc;
    int         last;
    int         maxl;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a search is described by its start timestamp, not a counter.
  bit         m_searching, m_holding, m_prevc;
  int         m_cyc, m_start_cyc;
  logic [7:0] m_cd;
  logic [3:0] m_cx, m_cy;
  logic [4:0] m_flags;
  int         m_cnt, m_sc, m_last, m_max;
  bit         m_irq;

  task automatic model_reset();
    m_searching = 0; m_holding = 0; m_prevc = 0;
    m_cyc = 0; m_start_cyc = 0;
    m_cd = '0; m_cx = '0; m_cy = '0;
    m_flags = '0; m_cnt = 0; m_sc = 0; m_last = 0; m_max = 0; m_irq = 0;
  endtask

  function automatic bit in_range(input logic [3:0] v);
    int sv;
    sv = $signed(v);
    return (sv >= MV_MIN) && (sv <= MV_MAX);
  endfunction

  task automatic model_step(input bit s, input bit c, input logic [7:0] d,
                            input logic [3:0] mx, input logic [3:0] my, input bit clr);
    int lat;
    bit acc;
    logic [4:0] e;
    exp_t x;
    lat = m_cyc - m_start_cyc + 1;
    if (lat > LAT_MAX) lat = LAT_MAX;
    acc  = m_searching && c && !s;
    e    = '0;
    e[0] = s && c;
    e[1] = m_searching && !c && (lat == TIMEOUT);
    e[2] = acc && !(in_range(mx) && in_range(my));
    e[3] = m_holding && c && ((d != m_cd) || (mx != m_cx) || (my != m_cy));
    e[4] = !m_searching && !m_holding && c && !m_prevc;

    if (m_searching) begin
      if (acc) begin
        m_searching = 0; m_holding = 1;
        m_cd = d; m_cx = mx; m_cy = my;
        m_last = lat;
        if (lat > m_max) m_max = lat;
        if (m_sc < CNT_MAX) m_sc++;
      end else if (e[1]) begin
        m_searching = 0;
      end
    end else if (m_holding) begin
      if (s) begin
        m_holding = 0; m_searching = 1; m_start_cyc = m_cyc + 1;
      end else if (!c) begin
        m_holding = 0;
      end
    end else if (s) begin
      m_searching = 1; m_start_cyc = m_cyc + 1;
    end

    if (clr) begin
      m_flags = e;
      m_cnt   = (e != 0) ? 1 : 0;
    end else begin
      m_flags = m_flags | e;
      if (e != 0 && m_cnt < CNT_MAX) m_cnt++;
    end
    m_irq   = (e != 0);
    m_prevc = c;
    m_cyc++;

    x.busy = m_searching; x.irq = m_irq; x.flags = m_flags;
    x.cnt = m_cnt; x.sc = m_sc; x.last = m_last; x.maxl = m_max;
    q.push_back(x);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  int'(busy), 0);
    chk({tag, "_irq"},   int'(irq), 0);
    chk({tag, "_flags"}, int'(err_flags), 0);
    chk({tag, "_cnt"},   int'(err_count), 0);
    chk({tag, "_sc"},    int'(search_count), 0);
    chk({tag, "_last"},  int'(last_latency), 0);
    chk({tag, "_max"},   int'(max_latency), 0);
  endtask

  // Monitor: outputs settled 1 time unit after the edge that consumed queued stimulus.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("busy",         int'(busy), int'(x.busy));
        chk("irq",          int'(irq), int'(x.irq));
        chk("err_flags",    int'(err_flags), int'(x.flags));
        chk("err_count",    int'(err_count), x.cnt);
        chk("search_count", int'(search_count), x.sc);
        chk("last_latency", int'(last_latency), x.last);
        chk("max_latency",  int'(max_latency), x.maxl);
      end
    end
  end

  task automatic drive(input bit s, input bit c, input int d, input int mx,
                       input int my, input bit clr);
    @(posedge clk);
    #2;
    start = s; completed = c; clear_errors = clr;
    BestDist = 8'(d); motionX = 4'(mx); motionY = 4'(my);
    model_step(s, c, 8'(d), 4'(mx), 4'(my), clr);
  endtask

  task automatic reset_mid_cycle();
    @(posedge clk);
    #2;
    start = 0; completed = 0; clear_errors = 0;
    rst = 1;
    #1;
    chk_all_zero("async_reset");
    model_reset();
    @(posedge clk);
    #2;
    rst = 0;
  endtask

  initial begin
    int rd, rx, ry;
    bit rs, rc, rclr;
    rst = 1; start = 0; completed = 0; clear_errors = 0;
    BestDist = '0; motionX = '0; motionY = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    rst = 0;
    #1;
    chk_all_zero("reset");

    // Nominal search: latency 3, motion (3,-2), then DONE instability and IDLE spurious.
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 'h20, 3, -2, 0);
    drive(0, 1, 'h20, 3, -2, 0);
    drive(0, 1, 'h21, 3, -2, 0);
    drive(0, 0, 'h21, 3, -2, 0);
    drive(0, 1, 'h21, 3, -2, 0);
    drive(0, 0, 0, 0, 0, 1);

    // start && completed inside BUSY: E0, completion refused.
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 5, 1, 1, 0);
    drive(0, 0, 5, 1, 1, 1);

    // Timeout: no completion for TIMEOUT busy cycles.
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < TIMEOUT + 2; i++) drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1);

    // Completion exactly in busy cycle TIMEOUT is accepted.
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < TIMEOUT - 1; i++) drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 9, 6, -7, 0);
    drive(0, 0, 9, 6, -7, 0);

    // Range limits: -8 and 7 lie outside [-7,6].
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 1, -8, 0, 0);
    drive(0, 0, 1, -8, 0, 1);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 7, 0);
    drive(0, 0, 1, 0, 7, 1);

    // Start in DONE with completed high: E0 and re-enter BUSY.
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 2, 1, 1, 0);
    drive(1, 1, 2, 1, 1, 0);
    drive(0, 1, 3, 2, 2, 0);
    drive(0, 0, 3, 2, 2, 0);

    // Clear coinciding with a new E0: detection wins.
    drive(1, 1, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a search.
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    reset_mid_cycle();

    rd = 0; rx = 0; ry = 0;
    for (int i = 0; i < 3000; i++) begin
      rs   = ($urandom_range(0, 5) == 0);
      rc   = ($urandom_range(0, 2) == 0);
      rclr = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 5) == 0) rd = $urandom_range(0, 255);
      if ($urandom_range(0, 5) == 0) rx = $urandom_range(0, 15);
      if ($urandom_range(0, 5) == 0) ry = $urandom_range(0, 15);
      drive(rs, rc, rd, rx, ry, rclr);
      if (i == 1500) reset_mid_cycle();
    end

    @(posedge clk);
    #3;
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
